tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter: BUSY_TIMEOUT, default 16'd1000, maximum number of cycles to wait for tx_busy to rise after a launch.
REQ-002 clk50m  input  1  system clock, 50 MHz; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on rising clk50m.
REQ-004 req_valid  input  3  per-requester byte-offer strobe; bit i belongs to requester i.
REQ-005 req_data0 / req_data1 / req_data2  input  8 each  byte offered by requester 0/1/2.
REQ-006 req_ready  output  3  bit i = 1 when requester i's holding buffer is empty.
REQ-007 tx_start  output  1  one-cycle launch pulse to the UART transmitter start input.
REQ-008 tx_data  output  8  byte presented to the UART transmitter data input.
REQ-009 tx_busy  input  1  UART transmitter busy flag.
REQ-010 grant_id  output  2  index of the requester last launched; 2'd3 = none since reset.
REQ-011 sent_count  output  8  bytes launched since reset; wraps 255 -> 0.
REQ-012 timeout_err  output  1  sticky flag for a tx_busy rise timeout.
REQ-013 idle  output  1  high when the FSM is in S_IDLE and all three buffers are empty.

Function
REQ-014 Buffers: one 8-bit holding register plus a full flag per requester.
REQ-015 req_ready[i] = ~full[i], decoded combinationally from the register.
REQ-016 Capture: when req_valid[i] && req_ready[i], store req_dataI and set full[i]. req_valid while full is ignored, and the byte is dropped.
REQ-017 FSM states and transitions:
- S_IDLE -> S_LAUNCH when any full[i] && !tx_busy.
- S_LAUNCH -> S_WAIT_BUSY after exactly 1 cycle.
- S_WAIT_BUSY -> S_WAIT_DONE when tx_busy == 1.
- S_WAIT_BUSY -> S_IDLE on timeout.
- S_WAIT_DONE -> S_IDLE when tx_busy == 0.
REQ-018 Arbitration (round-robin, evaluated in S_IDLE on the transition cycle):
- Search order starts at (grant_id + 1) mod 3.
- After reset, grant_id = 3, so the order is 0, 1, 2.
REQ-019 On the S_IDLE -> S_LAUNCH edge:
- tx_data <= winner's buffer.
- grant_id <= winner.
- full[winner] <= 0.
REQ-020 tx_start = 1 only while the FSM is in S_LAUNCH, so the pulse is exactly 1 cycle per byte.
REQ-021 Latency: tx_start is high 2 cycles after the capture edge when the FSM is idle and tx_busy = 0.
REQ-022 tx_data holds stable from S_LAUNCH until the next launch, and never changes while tx_busy = 1.
REQ-023 sent_count increments by 1 on each S_LAUNCH cycle; 8-bit wrap-around.
REQ-024 Timeout: a 16-bit counter clears on entry to S_WAIT_BUSY and increments each cycle there.
- When it reaches BUSY_TIMEOUT: set timeout_err and return to S_IDLE.
- The byte counts as sent and is not retried.
REQ-025 Simultaneous capture of requester i in the same cycle as requester i's launch is impossible, because req_ready[i] = 0. Capture is possible the cycle after S_LAUNCH.
REQ-026 Captures on other requesters proceed in every state, including during transmission.
REQ-027 If tx_busy is already 1 in S_IDLE (an external transmission in progress), the FSM holds S_IDLE.

Reset
REQ-028 While reset = 0 at a clock edge, the block SHALL set:
- state = S_IDLE
- full = 3'b000
- tx_start = 0
- tx_data = 8'h00
- grant_id = 2'd3
- sent_count = 0
- timeout_err = 0
- timeout counter = 0
REQ-029 Reset mid-transmission:
- The block abandons the buffer and FSM state.
- It does not reassert tx_start.
- After reset, the FSM waits in S_IDLE until tx_busy = 0 before the next launch.
REQ-030 No output responds asynchronously to reset; the first post-reset values appear after the edge.

Verification
REQ-031 Single byte: req_valid = 3'b010, req_data1 = 8'hA5, tx_busy modelled 1 cycle after start for 10 cycles -> one tx_start pulse 2 cycles later, tx_data = A5, grant_id = 1, sent_count = 1, req_ready[1] high again after S_LAUNCH.
REQ-032 Round-robin: all three buffers loaded in one cycle with 11/22/33 -> launch order 11, 22, 33. Then reload 0 and 2 with grant_id = 2 -> order 0, then 2.
REQ-033 Backpressure: a second req_valid[0] with 8'h77 while buffer 0 is full -> 8'h77 is never transmitted; the original byte is sent exactly once.
REQ-034 Timeout: BUSY_TIMEOUT = 5, tx_busy stuck at 0 -> timeout_err = 1 five cycles after S_WAIT_BUSY entry, FSM back in S_IDLE, next byte launches normally.
REQ-035 Reset mid-transmission: reset = 0 for 1 cycle during S_WAIT_DONE with buffer 2 full -> all REQ-028 values. No tx_start until tx_busy = 0 and a new capture.
REQ-036 Wrap: 256 launches -> sent_count = 0.

Source files
------------

// File: rtl/tx_arbiter.sv
// tx_arbiter: three single-byte holding buffers arbitrated round-robin onto
// one UART transmitter. Each launch gives a one-cycle tx_start pulse. The FSM
// then waits for tx_busy to rise and fall. If tx_busy does not rise within
// BUSY_TIMEOUT cycles, a sticky timeout_err is set.
//
// state        | meaning
// S_IDLE       | waiting for a full buffer while the transmitter is not busy
// S_LAUNCH     | tx_start high for one cycle; tx_data holds the winner's byte
// S_WAIT_BUSY  | waiting for tx_busy to rise; the timeout counter runs here
// S_WAIT_DONE  | transmitter busy; waiting for tx_busy to fall
module tx_arbiter #(
    parameter logic [15:0] BUSY_TIMEOUT = 16'd1000
) (
    input  logic       clk50m,
    input  logic       reset,
    input  logic [2:0] req_valid,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    input  logic [7:0] req_data2,
    output logic [2:0] req_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic [1:0] grant_id,
    output logic [7:0] sent_count,
    output logic       timeout_err,
    output logic       idle
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  full_q, full_d;
    logic [7:0]  buf_q [3];
    logic [7:0]  buf_d [3];
    logic [7:0]  tx_data_q, tx_data_d;
    logic [1:0]  grant_q, grant_d;
    logic [7:0]  sent_q, sent_d;
    logic        terr_q, terr_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [15:0] tcnt_inc;

    logic [7:0]  req_data [3];
    logic [1:0]  arb_c0, arb_c1, arb_c2;
    logic [1:0]  arb_win;
    logic        arb_any;

    assign req_data[0] = req_data0;
    assign req_data[1] = req_data1;
    assign req_data[2] = req_data2;

    // Successor of a requester index in the round-robin ring 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] ring_next(input logic [1:0] i);
        return (i >= 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Round-robin pick. grant_id = 3 after reset, so the search starts at 0.
    always_comb begin
        arb_c0  = (grant_q == 2'd3) ? 2'd0 : ring_next(grant_q);
        arb_c1  = ring_next(arb_c0);
        arb_c2  = ring_next(arb_c1);
        arb_any = |full_q;
        if (full_q[arb_c0]) begin
            arb_win = arb_c0;
        end else if (full_q[arb_c1]) begin
            arb_win = arb_c1;
        end else begin
            arb_win = arb_c2;
        end
    end

    assign tcnt_inc = tcnt_q + 16'd1;

    // Buffer capture, FSM next state and datapath updates.
    always_comb begin
        state_d   = state_q;
        full_d    = full_q;
        buf_d     = buf_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        sent_d    = sent_q;
        terr_d    = terr_q;
        tcnt_d    = tcnt_q;

        // A valid strobe on a full buffer is dropped. The launch below only
        // clears a buffer that is full, so it never collides with a capture
        // into the same buffer.
        for (int i = 0; i < 3; i++) begin
            if (req_valid[i] && !full_q[i]) begin
                full_d[i] = 1'b1;
                buf_d[i]  = req_data[i];
            end
        end

        unique case (state_q)
            S_IDLE: begin
                // No launch while an external transmission holds tx_busy.
                if (arb_any && !tx_busy) begin
                    state_d         = S_LAUNCH;
                    tx_data_d       = buf_q[arb_win];
                    grant_d         = arb_win;
                    full_d[arb_win] = 1'b0;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_BUSY;
                tcnt_d  = 16'd0;
                sent_d  = sent_q + 8'd1;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tcnt_inc >= BUSY_TIMEOUT) begin
                    // The byte counts as sent and is not retried.
                    state_d = S_IDLE;
                    terr_d  = 1'b1;
                    tcnt_d  = tcnt_inc;
                end else begin
                    tcnt_d  = tcnt_inc;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk50m) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            full_q    <= 3'b000;
            buf_q[0]  <= 8'h00;
            buf_q[1]  <= 8'h00;
            buf_q[2]  <= 8'h00;
            tx_data_q <= 8'h00;
            grant_q   <= 2'd3;
            sent_q    <= 8'h00;
            terr_q    <= 1'b0;
            tcnt_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            buf_q     <= buf_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            sent_q    <= sent_d;
            terr_q    <= terr_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign req_ready   = ~full_q;
    assign tx_start    = (state_q == S_LAUNCH);
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign sent_count  = sent_q;
    assign timeout_err = terr_q;
    assign idle        = (state_q == S_IDLE) && (full_q == 3'b000);

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter. A scoreboard queue holds the expected launches. Each
// tx_start pulse pops one entry and compares it. A small UART model raises
// tx_busy one cycle after a launch and holds it for a programmable length.
`timescale 1ns/1ps
module tb_tx_arbiter;

    logic       clk50m = 1'b0;
    logic       reset;
    logic [2:0] req_valid;
    logic [7:0] req_data0, req_data1, req_data2;
    logic [2:0] req_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic [1:0] grant_id;
    logic [7:0] sent_count;
    logic       timeout_err;
    logic       idle;

    always #10 clk50m = ~clk50m;

    tx_arbiter #(.BUSY_TIMEOUT(16'd5)) dut (
        .clk50m      (clk50m),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .req_data2   (req_data2),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .sent_count  (sent_count),
        .timeout_err (timeout_err),
        .idle        (idle)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] id;
    } exp_t;

    typedef struct {
        logic [2:0] valid;
        logic [7:0] d0, d1, d2;
        int         n;
        logic [1:0] id0, id1, id2;
        logic [7:0] dat0, dat1, dat2;
        logic [1:0] grant_after;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vecs[8];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         exp_sent = 0;
    logic       model_en = 1'b1;
    int         busy_len = 3;
    int         busy_cnt = 0;
    logic       pending  = 1'b0;
    logic       have_last = 1'b0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] wd;
    int         wr;
    int         kk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk50m);
        #1;
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic [1:0] id);
        exp_t e;
        e.data = d;
        e.id   = id;
        exp_q.push_back(e);
    endtask

    task automatic offer(input logic [2:0] v, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2);
        req_valid = v;
        req_data0 = d0;
        req_data1 = d1;
        req_data2 = d2;
        tick();
        req_valid = 3'b000;
    endtask

    task automatic apply_reset();
        have_last = 1'b0;
        req_valid = 3'b000;
        reset     = 1'b0;
        tick();
        tick();
        reset     = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"},    req_ready,   3'b111);
        check({tag, "_start"},    tx_start,    1'b0);
        check({tag, "_data"},     tx_data,     8'h00);
        check({tag, "_grant"},    grant_id,    2'd3);
        check({tag, "_sent"},     sent_count,  8'd0);
        check({tag, "_timeout"},  timeout_err, 1'b0);
        check({tag, "_idle"},     idle,        1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (!(idle && !tx_busy && !pending && exp_q.size() == 0) && k < budget) begin
            tick();
            k++;
        end
        check("wait_idle_in_budget", (k < budget), 1'b1);
    endtask

    // UART transmitter model: busy rises one cycle after tx_start, lasts busy_len cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk50m);
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
            if (pending) begin
                tx_busy  = 1'b1;
                busy_cnt = busy_len;
                pending  = 1'b0;
            end
            if (model_en && tx_start === 1'b1) pending = 1'b1;
        end
    end

    // Scoreboard: every launch pops one expectation; tx_data must then hold.
    initial begin
        forever begin
            @(negedge clk50m);
            if (tx_start === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_start: tx_data %0h grant %0d, no launch expected",
                             tx_data, grant_id);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("launch_data",  tx_data,  e.data);
                    check("launch_grant", grant_id, e.id);
                    last_data = e.data;
                    have_last = 1'b1;
                end
            end else if (have_last) begin
                check("tx_data_hold", tx_data, last_data);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'b111, 8'h11, 8'h22, 8'h33, 3, 2'd0, 2'd1, 2'd2, 8'h11, 8'h22, 8'h33, 2'd2};
        vecs[1] = '{3'b101, 8'h44, 8'h00, 8'h66, 2, 2'd0, 2'd2, 2'd0, 8'h44, 8'h66, 8'h00, 2'd2};
        vecs[2] = '{3'b110, 8'h00, 8'h5A, 8'hC3, 2, 2'd1, 2'd2, 2'd0, 8'h5A, 8'hC3, 8'h00, 2'd2};
        vecs[3] = '{3'b011, 8'h01, 8'h02, 8'h00, 2, 2'd0, 2'd1, 2'd0, 8'h01, 8'h02, 8'h00, 2'd1};
        vecs[4] = '{3'b101, 8'hF0, 8'h00, 8'h0F, 2, 2'd2, 2'd0, 2'd0, 8'h0F, 8'hF0, 8'h00, 2'd0};
        vecs[5] = '{3'b010, 8'h00, 8'h99, 8'h00, 1, 2'd1, 2'd0, 2'd0, 8'h99, 8'h00, 8'h00, 2'd1};
        vecs[6] = '{3'b111, 8'hAA, 8'hBB, 8'hCC, 3, 2'd2, 2'd0, 2'd1, 8'hCC, 8'hAA, 8'hBB, 2'd1};
        vecs[7] = '{3'b001, 8'h3C, 8'h00, 8'h00, 1, 2'd0, 2'd0, 2'd0, 8'h3C, 8'h00, 8'h00, 2'd0};

        req_valid = 3'b000;
        req_data0 = 8'h00;
        req_data1 = 8'h00;
        req_data2 = 8'h00;
        reset     = 1'b0;

        apply_reset();
        check_reset_vals("rst");

        // Single byte from requester 1.
        busy_len = 10;
        expect_byte(8'hA5, 2'd1);
        offer(3'b010, 8'h00, 8'hA5, 8'h00);
        check("t1_ready_full", req_ready, 3'b101);
        check("t1_no_start_yet", tx_start, 1'b0);
        tick();
        check("t1_start", tx_start, 1'b1);
        check("t1_data", tx_data, 8'hA5);
        check("t1_grant", grant_id, 2'd1);
        check("t1_ready_back", req_ready, 3'b111);
        tick();
        check("t1_pulse_one_cycle", tx_start, 1'b0);
        check("t1_sent", sent_count, 8'd1);
        wait_idle(100);
        exp_sent = 1;
        check("t1_sent_final", sent_count, 8'(exp_sent));

        // Round-robin table starting from reset.
        apply_reset();
        exp_sent = 0;
        busy_len = 3;
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].n > 0) expect_byte(vecs[v].dat0, vecs[v].id0);
            if (vecs[v].n > 1) expect_byte(vecs[v].dat1, vecs[v].id1);
            if (vecs[v].n > 2) expect_byte(vecs[v].dat2, vecs[v].id2);
            offer(vecs[v].valid, vecs[v].d0, vecs[v].d1, vecs[v].d2);
            wait_idle(300);
            exp_sent += vecs[v].n;
            check("rr_sent", sent_count, 8'(exp_sent));
            check("rr_grant_after", grant_id, vecs[v].grant_after);
        end

        // Backpressure: 8'h77 offered while buffer 0 is full is dropped.
        busy_len = 10;
        expect_byte(8'h12, 2'd1);
        expect_byte(8'h55, 2'd0);
        req_valid = 3'b010;
        req_data1 = 8'h12;
        tick();
        req_valid = 3'b001;
        req_data0 = 8'h55;
        tick();
        check("bp_ready_after_capture", req_ready, 3'b110);
        req_data0 = 8'h77;
        tick();
        check("bp_ready0_low", req_ready[0], 1'b0);
        req_valid = 3'b000;
        wait_idle(200);
        exp_sent += 2;
        check("bp_sent", sent_count, 8'(exp_sent));

        // Timeout: the UART never raises busy.
        model_en = 1'b0;
        expect_byte(8'h7E, 2'd2);
        offer(3'b100, 8'h00, 8'h00, 8'h7E);
        tick();
        check("to_start", tx_start, 1'b1);
        tick();
        check("to_err_on_entry", timeout_err, 1'b0);
        repeat (4) tick();
        check("to_err_before", timeout_err, 1'b0);
        check("to_not_idle_yet", idle, 1'b0);
        tick();
        check("to_err_set", timeout_err, 1'b1);
        check("to_back_idle", idle, 1'b1);
        model_en = 1'b1;
        expect_byte(8'h81, 2'd0);
        offer(3'b001, 8'h81, 8'h00, 8'h00);
        wait_idle(200);
        exp_sent += 2;
        check("to_sent", sent_count, 8'(exp_sent));
        check("to_err_sticky", timeout_err, 1'b1);

        // Reset during S_WAIT_DONE with buffer 2 full.
        busy_len = 10;
        expect_byte(8'h2B, 2'd1);
        req_valid = 3'b010;
        req_data1 = 8'h2B;
        tick();
        req_valid = 3'b100;
        req_data2 = 8'h3C;
        tick();
        req_valid = 3'b000;
        check("mr_start", tx_start, 1'b1);
        kk = 0;
        while (!tx_busy && kk < 20) begin
            tick();
            kk++;
        end
        check("mr_busy_rose", tx_busy, 1'b1);
        tick();
        check("mr_buf2_full", req_ready, 3'b011);
        have_last = 1'b0;
        reset = 1'b0;
        tick();
        check_reset_vals("mr");
        reset = 1'b1;
        expect_byte(8'h4D, 2'd0);
        offer(3'b001, 8'h4D, 8'h00, 8'h00);
        kk = 0;
        while (tx_busy && kk < 40) begin
            check("mr_no_start_while_busy", tx_start, 1'b0);
            tick();
            kk++;
        end
        check("mr_busy_fell", tx_busy, 1'b0);
        wait_idle(100);
        check("mr_sent", sent_count, 8'd1);
        check("mr_grant", grant_id, 2'd0);

        // sent_count wrap after 256 launches.
        apply_reset();
        busy_len = 1;
        for (int i = 0; i < 256; i++) begin
            wd = 8'(i);
            wr = i % 3;
            expect_byte(wd, 2'(wr));
            offer(3'(1 << wr), wd, wd, wd);
            wait_idle(50);
            if (i == 254) check("wrap_255", sent_count, 8'd255);
        end
        check("wrap_zero", sent_count, 8'd0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
